// File: rtl/seq_det_pkg.sv
// Shared types and constants for the round-robin "1010" sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_det_core.sv
// Combinational next-state/match logic for one overlapping "1010" detector,
// shared by all channels through the grant mux in the top level.
module seq_det_core
  import seq_det_pkg::*;
(
  input  det_state_t cur_state,
  input  logic       din,
  output det_state_t next_state,
  output logic       match
);

  always_comb begin
    next_state = cur_state;
    match      = 1'b0;
    unique case (cur_state)
      S0: next_state = din ? S1 : S0;
      S1: next_state = din ? S1 : S2;
      S2: next_state = din ? S3 : S0;
      S3: begin
        next_state = din ? S1 : S2;
        match      = (din == PATTERN[0]);
      end
    endcase
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter feeding per-channel "1010" detectors through one shared core.
// Optional per-channel saturating match counters: define SEQ_DET_ARB_MATCH_CNT_EN.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          bit_in,
  input  logic [NUM_CH-1:0]          ch_clr,
  output logic [NUM_CH-1:0]          gnt,
  output logic                       det_valid,
  output logic [$clog2(NUM_CH)-1:0]  det_ch
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]    match_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W:0]   NUM_CH_V = (IDX_W+1)'(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] cand_idx [NUM_CH];
  logic [IDX_W-1:0] grant_idx;
  logic             xfer;
  logic             det_hit;
  det_state_t       cur_state [NUM_CH];
  det_state_t       core_next;
  logic             core_match;

  // Candidate k is the channel k positions after the round-robin pointer.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= NUM_CH_V) ? IDX_W'(sum - NUM_CH_V) : sum[IDX_W-1:0];
  end

  always_comb begin
    xfer      = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!xfer && req[cand_idx[k]]) begin
        xfer      = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    if (reset) xfer = 1'b0;
    gnt = xfer ? (NUM_CH'(1) << grant_idx) : '0;
  end

  seq_det_core u_core (
    .cur_state  (cur_state[grant_idx]),
    .din        (bit_in[grant_idx]),
    .next_state (core_next),
    .match      (core_match)
  );

  // A clear on the granted channel discards its bit, so it cannot match.
  assign det_hit = xfer && core_match && !ch_clr[grant_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      det_valid  <= 1'b0;
      det_ch     <= '0;
    end else begin
      det_valid <= det_hit;
      if (det_hit) det_ch <= grant_idx;
      if (xfer) rr_ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    det_state_t state_reg;
    logic       sel;
    assign sel           = xfer && (grant_idx == IDX_W'(gi));
    assign cur_state[gi] = state_reg;

    always_ff @(posedge clk) begin
      if (reset)           state_reg <= S0;
      else if (ch_clr[gi]) state_reg <= S0;
      else if (sel)        state_reg <= core_next;
    end

`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset)                                         cnt_reg <= '0;
      else if (ch_clr[gi])                               cnt_reg <= '0;
      else if (det_hit && sel && (cnt_reg != '1))        cnt_reg <= cnt_reg + 1'b1;
    end
    assign match_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
  end

`ifndef SEQ_DET_ARB_MATCH_CNT_EN
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed table-driven bench for seq_det_arbiter (NUM_CH=4, CNT_W=2).
module tb_seq_det_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, bit_in, ch_clr, gnt;
  logic       det_valid;
  logic [1:0] det_ch;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
  logic [7:0] match_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] gnt_pre;

  always #5 clk = ~clk;

  seq_det_arbiter #(.NUM_CH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bit_in    (bit_in),
    .ch_clr    (ch_clr),
    .gnt       (gnt),
    .det_valid (det_valid),
    .det_ch    (det_ch)
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] bits;
    logic [3:0] clr;
    logic [3:0] gnt;
    logic       dv;
    logic [1:0] ch;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, b, c, g, input logic dv, input logic [1:0] ch);
    vec_t v;
    v.req = r; v.bits = b; v.clr = c; v.gnt = g; v.dv = dv; v.ch = ch;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; gnt is captured combinationally before the edge.
  task automatic cycle(input logic [3:0] r, b, c);
    req = r; bit_in = b; ch_clr = c;
    #1;
    gnt_pre = gnt;
    @(posedge clk);
    #1;
    $display("cyc req=%b bit=%b clr=%b gnt=%b -> dv=%b ch=%0d", r, b, c, gnt_pre, det_valid, det_ch);
  endtask

  initial begin
    reset = 1'b1; req = 4'hF; bit_in = 4'h0; ch_clr = 4'h0;

    // Round robin from reset over all four requesters.
    add(4'hF, 4'h0, 4'h0, 4'b0001, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b0010, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b0100, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b1000, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b0001, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b0010, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b0100, 0, 0);
    add(4'hF, 4'h0, 4'h0, 4'b1000, 0, 0);
    add(4'h0, 4'h0, 4'h0, 4'b0000, 0, 0);
    // Channel 0: 1010, then 10 again (left in S2 after a match).
    add(4'h1, 4'h1, 4'h0, 4'b0001, 0, 0);
    add(4'h1, 4'h0, 4'h0, 4'b0001, 0, 0);
    add(4'h1, 4'h1, 4'h0, 4'b0001, 0, 0);
    add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0);
    add(4'h1, 4'h1, 4'h0, 4'b0001, 0, 0);
    add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0);
    // Channel 1: 101010, overlapping matches.
    add(4'h2, 4'h2, 4'h0, 4'b0010, 0, 0);
    add(4'h2, 4'h0, 4'h0, 4'b0010, 0, 0);
    add(4'h2, 4'h2, 4'h0, 4'b0010, 0, 0);
    add(4'h2, 4'h0, 4'h0, 4'b0010, 1, 1);
    add(4'h2, 4'h2, 4'h0, 4'b0010, 0, 0);
    add(4'h2, 4'h0, 4'h0, 4'b0010, 1, 1);
    // No request: bits ignored.
    add(4'h0, 4'hF, 4'h0, 4'b0000, 0, 0);
    // Clear ch0/ch2 while ch2 transfers: pointer still advances to 3.
    add(4'h4, 4'h4, 4'h5, 4'b0100, 0, 0);
    // ch0 and ch2 interleaved under contention.
    add(4'h5, 4'h5, 4'h0, 4'b0001, 0, 0);
    add(4'h5, 4'h5, 4'h0, 4'b0100, 0, 0);
    add(4'h5, 4'h0, 4'h0, 4'b0001, 0, 0);
    add(4'h5, 4'h0, 4'h0, 4'b0100, 0, 0);
    add(4'h5, 4'h5, 4'h0, 4'b0001, 0, 0);
    add(4'h5, 4'h5, 4'h0, 4'b0100, 0, 0);
    add(4'h5, 4'h0, 4'h0, 4'b0001, 1, 0);
    add(4'h5, 4'h0, 4'h0, 4'b0100, 1, 2);
    // ch1 history survived the other channels' traffic.
    add(4'h2, 4'h2, 4'h0, 4'b0010, 0, 0);
    add(4'h2, 4'h0, 4'h0, 4'b0010, 1, 1);
    // ch3 to S3, then clear coincident with a matching 0.
    add(4'h8, 4'h8, 4'h0, 4'b1000, 0, 0);
    add(4'h8, 4'h0, 4'h0, 4'b1000, 0, 0);
    add(4'h8, 4'h8, 4'h0, 4'b1000, 0, 0);
    add(4'h8, 4'h0, 4'h8, 4'b1000, 0, 0);
    add(4'h8, 4'h8, 4'h0, 4'b1000, 0, 0);
    add(4'h8, 4'h0, 4'h0, 4'b1000, 0, 0);
    add(4'h8, 4'h8, 4'h0, 4'b1000, 0, 0);
    add(4'h8, 4'h0, 4'h0, 4'b1000, 1, 3);

    // Reset phase: grant must be suppressed.
    @(posedge clk); #1;
    check("gnt_in_reset", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    check("dv_after_reset", 32'(det_valid), 32'h0);
    check("ch_after_reset", 32'(det_ch), 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].req, vecs[i].bits, vecs[i].clr);
      check($sformatf("gnt_v%0d", i), 32'(gnt_pre), 32'(vecs[i].gnt));
      check($sformatf("dv_v%0d", i), 32'(det_valid), 32'(vecs[i].dv));
      if (vecs[i].dv) check($sformatf("ch_v%0d", i), 32'(det_ch), 32'(vecs[i].ch));
    end
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    check("cnt_after_table", 32'(match_cnt), 32'h5D);
`endif

    // Reset while ch0 sits in S3: the following 0 must not match.
    cycle(4'h0, 4'h0, 4'h1);
    cycle(4'h1, 4'h1, 4'h0);
    cycle(4'h1, 4'h0, 4'h0);
    cycle(4'h1, 4'h1, 4'h0);
    check("dv_before_mid_reset", 32'(det_valid), 32'h0);
    reset = 1'b1; req = 4'h1; bit_in = 4'h0; ch_clr = 4'h0;
    #1;
    check("gnt_mid_reset", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    check("dv_mid_reset", 32'(det_valid), 32'h0);
    check("ch_mid_reset", 32'(det_ch), 32'h0);
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    check("cnt_mid_reset", 32'(match_cnt), 32'h0);
`endif
    reset = 1'b0;
    cycle(4'hF, 4'h0, 4'h0);
    check("gnt_rr_after_reset", 32'(gnt_pre), 32'h1);
    check("dv_no_stale_match", 32'(det_valid), 32'h0);

    // Five matches on ch0 to saturate a 2-bit counter.
    for (int i = 0; i < 12; i++) begin
      cycle(4'h1, (i % 2 == 0) ? 4'h1 : 4'h0, 4'h0);
      check($sformatf("dv_sat%0d", i), 32'(det_valid), (i >= 3 && i % 2 == 1) ? 32'h1 : 32'h0);
    end
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    check("cnt_saturated", 32'(match_cnt), 32'h3);
`endif
    reset = 1'b1;
    cycle(4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    check("dv_final_reset", 32'(det_valid), 32'h0);
    check("ch_final_reset", 32'(det_ch), 32'h0);
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    check("cnt_final_reset", 32'(match_cnt), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
